// File: rtl/mac_feeder.sv
// rtl/mac_feeder.sv - operand FIFO and dot-product job sequencer feeding a 16x16 signed MAC
module mac_feeder #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] length,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    output logic [2:0]       instruction,
    output logic [15:0]      multiplier,
    output logic [15:0]      multiplicand,
    output logic             stall,
    output logic             busy,
    output logic             done
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, CLEAR, FIRST, ACCUM, DONE} state_t;

    state_t           state, state_nx;
    logic [15:0]      mem_a [DEPTH];
    logic [15:0]      mem_b [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [LEN_W-1:0] len_q, len_nx, cnt, cnt_nx;
    logic [2:0]       instr_nx;
    logic [15:0]      mult_nx, mcand_nx;
    logic             stall_nx, busy_nx, done_nx;
    logic             push, pop, empty;

    assign empty    = (count == '0);
    assign in_ready = (count != (AW+1)'(DEPTH));
    assign push     = in_valid && in_ready;

    // Outputs are computed for the edge that ends the current state, then registered.
    always_comb begin
        state_nx = state;
        len_nx   = len_q;
        cnt_nx   = cnt;
        instr_nx = instruction;
        mult_nx  = multiplier;
        mcand_nx = multiplicand;
        stall_nx = stall;
        busy_nx  = busy;
        done_nx  = 1'b0;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                stall_nx = 1'b1;
                busy_nx  = 1'b0;
                if (start) begin
                    len_nx   = length;
                    cnt_nx   = '0;
                    instr_nx = 3'b000;
                    stall_nx = 1'b0;
                    busy_nx  = 1'b1;
                    state_nx = CLEAR;
                end
            end
            CLEAR, FIRST, ACCUM: begin
                if (cnt == len_q) begin
                    stall_nx = 1'b1;
                    done_nx  = 1'b1;
                    state_nx = DONE;
                end else if (empty) begin
                    stall_nx = 1'b1;
                    if (state == CLEAR)
                        state_nx = FIRST;
                end else begin
                    pop      = 1'b1;
                    instr_nx = (state == ACCUM) ? 3'b010 : 3'b001;
                    mult_nx  = mem_a[rd_ptr];
                    mcand_nx = mem_b[rd_ptr];
                    stall_nx = 1'b0;
                    cnt_nx   = cnt + LEN_W'(1);
                    state_nx = ACCUM;
                end
            end
            DONE: begin
                stall_nx = 1'b1;
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            len_q        <= '0;
            cnt          <= '0;
            instruction  <= 3'b000;
            multiplier   <= '0;
            multiplicand <= '0;
            stall        <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nx;
            len_q        <= len_nx;
            cnt          <= cnt_nx;
            instruction  <= instr_nx;
            multiplier   <= mult_nx;
            multiplicand <= mcand_nx;
            stall        <= stall_nx;
            busy         <= busy_nx;
            done         <= done_nx;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (pop && !push)
                count <= count - (AW+1)'(1);
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end
endmodule

// File: tb/tb_mac_feeder.sv
// tb/tb_mac_feeder.sv - self-checking bench for mac_feeder with a job-level reference model
module tb_mac_feeder;
    localparam int DEPTH = 4;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             reset, start, in_valid, in_ready;
    logic [LEN_W-1:0] length;
    logic [15:0]      in_a, in_b, multiplier, multiplicand;
    logic [2:0]       instruction;
    logic             stall, busy, done;

    always #5 clk = ~clk;

    mac_feeder #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .length(length),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .instruction(instruction), .multiplier(multiplier), .multiplicand(multiplicand),
        .stall(stall), .busy(busy), .done(done)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of accepted pairs and a three-phase job view.
    logic signed [15:0] qa[$];
    logic signed [15:0] qb[$];
    int                 phase = 0;
    int                 n_terms = 0;
    int                 issued = 0;
    logic [2:0]         e_instr;
    logic signed [15:0] e_mult, e_mcand;
    logic               e_stall, e_busy, e_done;
    bit                 mvalid = 0;

    always @(posedge clk) begin
        bit mpush;
        mpush = in_valid && (qa.size() < DEPTH);
        if (reset) begin
            qa.delete();
            qb.delete();
            phase   = 0;
            e_instr = 3'b000;
            e_mult  = 0;
            e_mcand = 0;
            e_stall = 1;
            e_busy  = 0;
            e_done  = 0;
            mvalid  = 1;
        end else begin
            e_done = 0;
            case (phase)
                0: begin
                    e_stall = 1;
                    e_busy  = 0;
                    if (start) begin
                        n_terms = int'(length);
                        issued  = 0;
                        e_instr = 3'b000;
                        e_stall = 0;
                        e_busy  = 1;
                        phase   = 1;
                    end
                end
                1: begin
                    if (issued == n_terms) begin
                        e_done  = 1;
                        e_stall = 1;
                        phase   = 2;
                    end else if (qa.size() == 0) begin
                        e_stall = 1;
                    end else begin
                        e_instr = (issued == 0) ? 3'b001 : 3'b010;
                        e_mult  = qa.pop_front();
                        e_mcand = qb.pop_front();
                        e_stall = 0;
                        issued++;
                    end
                end
                default: begin
                    e_stall = 1;
                    e_busy  = 0;
                    phase   = 0;
                end
            endcase
            if (mpush) begin
                qa.push_back(in_a);
                qb.push_back(in_b);
            end
        end
    end

    // Downstream MAC behaviour, driven only by what the DUT presents.
    longint acc = 0;

    always @(negedge clk) begin
        if (mvalid) begin
            chk("instruction", instruction, e_instr);
            chk("multiplier", $signed(multiplier), e_mult);
            chk("multiplicand", $signed(multiplicand), e_mcand);
            chk("stall", stall, e_stall);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("in_ready", in_ready, qa.size() < DEPTH);
            if (!stall) begin
                case (instruction)
                    3'b000: acc = 0;
                    3'b001: acc = longint'($signed(multiplier)) * longint'($signed(multiplicand));
                    3'b010: acc = acc + longint'($signed(multiplier)) * longint'($signed(multiplicand));
                    default: ;
                endcase
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int a, input int b);
        bit taken;
        int budget;
        budget = 0;
        in_valid = 1;
        in_a = a[15:0];
        in_b = b[15:0];
        do begin
            taken = in_ready;
            tick();
            budget++;
        end while (!taken && budget < 50);
        in_valid = 0;
        if (!taken)
            chk("push_timeout", 0, 1);
    endtask

    task automatic pulse_start(input int len);
        start = 1;
        length = len[LEN_W-1:0];
        tick();
        start = 0;
    endtask

    task automatic wait_done(output int terms, input int budget);
        bit seen;
        seen = 0;
        terms = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (!stall && instruction != 3'b000)
                terms++;
            if (done)
                seen = 1;
        end
        if (!seen)
            chk("done_timeout", 0, 1);
    endtask

    int terms;

    initial begin
        reset = 1; start = 0; length = '0; in_valid = 0; in_a = '0; in_b = '0;
        tick(); tick();
        reset = 0;

        // Reset for two cycles in the middle of a job with a push pending
        push(5, 5); push(6, 6);
        pulse_start(3);
        in_valid = 1; in_a = 16'd9; in_b = 16'd9;
        tick();
        reset = 1;
        tick();
        chk("rst_instruction", instruction, 0);
        chk("rst_multiplier", multiplier, 0);
        chk("rst_multiplicand", multiplicand, 0);
        chk("rst_stall", stall, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 1);
        tick();
        reset = 0; in_valid = 0;
        tick();

        // Preloaded job of three terms
        push(2, 3); push(-4, 5); push(7, -1);
        pulse_start(3);
        chk("pre_e0_instr", instruction, 0);
        chk("pre_e0_stall", stall, 0);
        chk("pre_e0_busy", busy, 1);
        tick();
        chk("pre_e1_instr", instruction, 1);
        chk("pre_e1_mult", $signed(multiplier), 2);
        chk("pre_e1_mcand", $signed(multiplicand), 3);
        tick();
        chk("pre_e2_mult", $signed(multiplier), -4);
        tick();
        chk("pre_e3_instr", instruction, 2);
        chk("pre_e3_mcand", $signed(multiplicand), -1);
        tick();
        chk("pre_e4_done", done, 1);
        chk("pre_e4_stall", stall, 1);
        chk("pre_result", acc, -21);
        tick();
        chk("pre_e5_busy", busy, 0);

        // Underflow: second operand arrives late
        push(100, -100);
        pulse_start(2);
        tick();
        chk("uf_e1_instr", instruction, 1);
        tick();
        chk("uf_e2_stall", stall, 1);
        chk("uf_e2_hold", $signed(multiplier), 100);
        in_valid = 1; in_a = 16'h8000; in_b = 16'h8000;
        tick();
        in_valid = 0;
        chk("uf_e3_stall", stall, 1);
        tick();
        chk("uf_e4_instr", instruction, 2);
        chk("uf_e4_mult", $signed(multiplier), -32768);
        chk("uf_e4_stall", stall, 0);
        tick();
        chk("uf_e5_done", done, 1);
        chk("uf_result", acc, 64'sd1073731824);
        tick();

        // Full FIFO: fifth pair held until the first pop
        push(1, -1); push(2, -2); push(3, -3); push(4, -4);
        chk("full_ready", in_ready, 0);
        in_valid = 1; in_a = 16'd5; in_b = -16'sd5;
        tick(); tick();
        chk("full_held", in_ready, 0);
        pulse_start(5);
        tick();
        chk("full_after_pop", in_ready, 1);
        tick();
        in_valid = 0;
        wait_done(terms, 50);
        chk("full_terms_after_e2", terms, 3);
        chk("full_result", acc, -55);
        tick();

        // Zero length leaves the FIFO alone
        push(11, 22);
        pulse_start(0);
        chk("zero_e0_instr", instruction, 0);
        tick();
        chk("zero_e1_done", done, 1);
        tick();
        chk("zero_idle", busy, 0);

        // Start re-pulsed mid-job is ignored
        push(33, 44); push(55, 66);
        pulse_start(3);
        tick();
        start = 1; length = 8'd7;
        tick();
        start = 0;
        wait_done(terms, 50);
        chk("repulse_terms_after_e2", terms, 1);
        chk("repulse_result", acc, 5324);
        tick(); tick();
        chk("repulse_no_restart", busy, 0);

        // Reset mid-job aborts without a done pulse
        push(1, 1); push(2, 2);
        pulse_start(4);
        tick();
        reset = 1;
        tick();
        reset = 0;
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        tick(); tick();
        push(-3, 9);
        pulse_start(1);
        wait_done(terms, 50);
        chk("abort_next_terms", terms, 1);
        chk("abort_next_result", acc, -27);
        tick();

        // Longest job streams without counter wrap
        in_valid = 1; in_a = 16'd1; in_b = 16'd1;
        pulse_start(255);
        wait_done(terms, 600);
        chk("max_terms", terms, 255);
        chk("max_result", acc, 255);
        in_valid = 0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mac_feeder.md
# mac_feeder

Operand sequencer directly upstream of the 16x16 signed MAC. It buffers signed operand pairs from a valid/ready producer in a small FIFO and issues a dot-product job of programmable length to the MAC. Each job is one clear, then one multiply-load, then multiply-accumulates. The block drives the MAC's `instruction`, `multiplier`, `multiplicand` and `stall` inputs, holding the MAC whenever operands are unavailable.

## Interface
- DEPTH, 4: operand FIFO entries (power of 2, ≥2)
- LEN_W, 8: width of job length field
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  job request, sampled only in IDLE
- length  in  LEN_W  number of terms N in the job, latched with start
- in_valid  in  1  producer has operand pair
- in_ready  out  1  FIFO not full (= !full, combinational)
- in_a  in  16  signed operand A
- in_b  in  16  signed operand B
- instruction  out  3  to MAC: 3'b000 clear, 3'b001 multiply-load, 3'b010 multiply-accumulate
- multiplier  out  16  signed, to MAC
- multiplicand  out  16  signed, to MAC
- stall  out  1  to MAC; 1 = MAC ignores current instruction
- busy  out  1  job in progress (state ≠ IDLE)
- done  out  1  one-cycle pulse at job completion

## Operation
- Reset is synchronous and active-high. On reset: FIFO flushed; state IDLE; instruction=3'b000, multiplier=0, multiplicand=0, stall=1, busy=0, done=0. in_ready is 1 after reset.
- FIFO behaviour:
  - Push on in_valid && in_ready, in any state, including IDLE (preload allowed).
  - Pop only on an issue edge.
  - Simultaneous push and pop on a non-empty FIFO leaves the count unchanged.
  - No push while full. Read-while-empty cannot occur.
- All MAC-side outputs, busy and done are registered.
- FSM:
  - IDLE: stall=1, done=0. If start=1, latch length → CLEAR.
  - CLEAR (one cycle): register instruction=000, stall=0. Term counter cnt=0. If N=0 → DONE, else → FIRST.
  - FIRST: if FIFO empty, register stall=1, instruction/operands hold. Else pop head, register instruction=001, multiplier=a, multiplicand=b, stall=0, cnt=1. If N=1 → DONE, else → ACCUM.
  - ACCUM: same as FIRST but instruction=010, cnt+1. When cnt+1==N → DONE.
  - DONE (one cycle): register stall=1, done=1 → IDLE.
- start outside IDLE is ignored. length changes after latch are ignored.
- Operands pass through bit-exact; no arithmetic is performed on them. cnt is LEN_W bits. N = 2^LEN_W−1 must complete without wrap.
- Reset mid-job aborts immediately: FIFO contents are discarded, no done pulse is produced, and the reset values above apply.

## Timing
- Define edge E0 as the edge where start is sampled in IDLE.
- After E0: instruction=000, stall=0, busy=1.
- Term k is issued at edge Ek (k=1..N), provided the FIFO was non-empty before that edge. A pair pushed at edge Ek−1 is issuable at Ek.
- Sustained throughput is 1 term/cycle. Each empty cycle inserts exactly one stall=1 cycle and delays the remaining terms by one edge.
- After the last issue edge EN (no underflow): the following edge registers done=1, stall=1, busy=1. The edge after that returns busy=0 and done=0.
- N=0: clear at E0, done=1 after E1.
- Earliest next start is sampled the cycle after done falls (IDLE). Back-to-back jobs therefore have 2 idle edges between the last term and the next clear.
- in_ready deasserts in the same cycle the FIFO becomes full. It reasserts in the cycle after a pop.

## Test plan
- Reset: assert reset 2 cycles mid-traffic. Required: instruction=000, multiplier=multiplicand=0, stall=1, busy=0, done=0, in_ready=1 on the first cycle after reset.
- Preloaded job: push (2,3), (−4,5), (7,−1), then start with length=3. Required after E0..E4: 000/s0; 001 2,3 s0; 010 −4,5 s0; 010 7,−1 s0; stall=1 with done=1. The downstream MAC result must be 6−20−7 = −21.
- Underflow: length=2, only (100,−100) preloaded, (−32768,−32768) pushed 3 cycles after start. Required: 001 issue at E1; stall=1 with operands held until the push; 010 −32768,−32768 issued on the edge after the push; done on the following edge.
- Full FIFO: in IDLE, push 5 pairs with DEPTH=4. Required: in_ready=0 after the 4th pair, 5th pair held. Then start with length=5: the 5th pair is accepted the cycle after the first pop, and all 5 pairs are issued in order.
- Zero length and start-while-busy: start length=0 → clear, then done=1 after E1, FIFO untouched. Re-pulse start mid-job (length=3) → ignored, exactly 3 terms issued.
- Reset mid-job: reset at E2 of a length=4 job. Required: no done pulse, FIFO empty (in_ready=1). A new length=1 job then runs cleanly.
